// File: rtl/treasure_scan_controller.sv
// Frame-level sequencer for the camera colour/shape classifier.
// Aligns to VSYNC, strobes the classifier statistics counters, confirms a
// treasure after CONFIRM_FRAMES identical frame codes and reports it to the
// Arduino over a VALID/ACK handshake with an ACK timeout.
module treasure_scan_controller #(
    parameter int CONFIRM_FRAMES = 3,
    parameter int MAX_FRAMES     = 15,
    parameter int ACK_TIMEOUT    = 25000000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       VSYNC,
    input  logic       ENABLE,
    input  logic       ACK,
    input  logic [1:0] RESULT_IN,
    input  logic [7:0] SHAPE_IN,
    output logic       CLEAR_STATS,
    output logic       LATCH_STATS,
    output logic [3:0] CODE,
    output logic       VALID,
    output logic       BUSY,
    output logic       TIMEOUT_ERR
);

    typedef enum logic [2:0] {
        IDLE, ALIGN, ACCUM, EVAL, WAIT_START, REPORT, RELEASE
    } state_t;

    localparam logic [3:0]  CONFIRM_W  = 4'(CONFIRM_FRAMES);
    localparam logic [7:0]  MAX_W      = 8'(MAX_FRAMES);
    localparam logic [29:0] TIMER_LAST = 30'(ACK_TIMEOUT - 1);

    // Colour in the upper pair, shape index in the lower pair; no colour means no treasure.
    function automatic logic [3:0] frame_code(input logic [1:0] colour, input logic [7:0] shape);
        logic [1:0] shape_idx;
        case (shape)
            8'b1110_0000: shape_idx = 2'b01;
            8'b0001_1100: shape_idx = 2'b10;
            8'b0000_0011: shape_idx = 2'b11;
            default:      shape_idx = 2'b00;
        endcase
        if (colour == 2'b00 || colour == 2'b11) begin
            frame_code = 4'b0000;
        end else begin
            frame_code = {colour, shape_idx};
        end
    endfunction

    logic        rst_p0, rst_p1;
    logic        vsync_p0, vsync_p1, vsync_p2;
    logic        ack_p0, ack_p1;
    logic        enable_p0;
    state_t      state, state_n;
    logic [3:0]  cand, cand_n;
    logic [3:0]  streak, streak_n, streak_eval;
    logic [7:0]  frames, frames_n, frames_eval;
    logic [29:0] timer, timer_n;
    logic [3:0]  code_q, code_n, code_now;
    logic        err_q, err_n;
    logic        vs_rise, vs_fall;

    // Reset asserts asynchronously and releases in step with CLK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rst_p0 <= 1'b0;
            rst_p1 <= 1'b0;
        end else begin
            rst_p0 <= 1'b1;
            rst_p1 <= rst_p0;
        end
    end

    // Synchronise the asynchronous camera/Arduino inputs and keep ENABLE history.
    always_ff @(posedge CLK or negedge rst_p1) begin
        if (!rst_p1) begin
            vsync_p0  <= 1'b0;
            vsync_p1  <= 1'b0;
            vsync_p2  <= 1'b0;
            ack_p0    <= 1'b0;
            ack_p1    <= 1'b0;
            enable_p0 <= 1'b0;
        end else begin
            vsync_p0  <= VSYNC;
            vsync_p1  <= vsync_p0;
            vsync_p2  <= vsync_p1;
            ack_p0    <= ACK;
            ack_p1    <= ack_p0;
            enable_p0 <= ENABLE;
        end
    end

    assign vs_rise = vsync_p1 & ~vsync_p2;
    assign vs_fall = ~vsync_p1 & vsync_p2;

    // State and scan bookkeeping registers.
    always_ff @(posedge CLK or negedge rst_p1) begin
        if (!rst_p1) begin
            state  <= IDLE;
            cand   <= 4'd0;
            streak <= 4'd0;
            frames <= 8'd0;
            timer  <= 30'd0;
            code_q <= 4'd0;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cand   <= cand_n;
            streak <= streak_n;
            frames <= frames_n;
            timer  <= timer_n;
            code_q <= code_n;
            err_q  <= err_n;
        end
    end

    // Next-state, frame evaluation and strobe generation.
    always_comb begin
        state_n     = state;
        cand_n      = cand;
        streak_n    = streak;
        frames_n    = frames;
        timer_n     = timer;
        code_n      = code_q;
        err_n       = err_q;
        CLEAR_STATS = 1'b0;
        LATCH_STATS = 1'b0;
        code_now    = frame_code(RESULT_IN, SHAPE_IN);
        frames_eval = frames + 8'd1;
        if (code_now == cand && streak != 4'd0) begin
            streak_eval = (streak == 4'd15) ? 4'd15 : streak + 4'd1;
        end else begin
            streak_eval = 4'd1;
        end

        if (ENABLE && !enable_p0) begin
            err_n = 1'b0;
        end

        case (state)
            IDLE: begin
                cand_n   = 4'd0;
                streak_n = 4'd0;
                frames_n = 8'd0;
                timer_n  = 30'd0;
                if (ENABLE) begin
                    state_n = ALIGN;
                end
            end
            ALIGN, WAIT_START: begin
                if (!ENABLE) begin
                    state_n = IDLE;
                end else if (vs_fall) begin
                    CLEAR_STATS = 1'b1;
                    state_n     = ACCUM;
                end
            end
            ACCUM: begin
                if (!ENABLE) begin
                    state_n = IDLE;
                end else if (vs_rise) begin
                    LATCH_STATS = 1'b1;
                    state_n     = EVAL;
                end
            end
            EVAL: begin
                if (!ENABLE) begin
                    state_n = IDLE;
                end else begin
                    cand_n   = code_now;
                    streak_n = streak_eval;
                    frames_n = frames_eval;
                    if (streak_eval == CONFIRM_W && code_now != 4'd0) begin
                        code_n  = code_now;
                        state_n = REPORT;
                    end else if (frames_eval == MAX_W) begin
                        code_n  = 4'd0;
                        state_n = REPORT;
                    end else begin
                        state_n = WAIT_START;
                    end
                end
            end
            REPORT: begin
                if (ack_p1) begin
                    timer_n = 30'd0;
                    state_n = RELEASE;
                end else if (timer == TIMER_LAST) begin
                    timer_n = 30'd0;
                    err_n   = 1'b1;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + 30'd1;
                end
            end
            RELEASE: begin
                if (!ack_p1) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign CODE        = code_q;
    assign VALID       = (state == REPORT);
    assign BUSY        = (state != IDLE);
    assign TIMEOUT_ERR = err_q;

endmodule

// File: tb/tb_treasure_scan_controller.sv
// Scoreboard bench for treasure_scan_controller: scans push the expected
// report code, a negedge monitor pops and compares on every VALID rise.
module tb_treasure_scan_controller;

    localparam int CONFIRM = 3;
    localparam int MAXF    = 15;
    localparam int TMO     = 100;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       VSYNC = 1'b1;
    logic       ENABLE = 1'b0;
    logic       ACK = 1'b0;
    logic [1:0] RESULT_IN = 2'b00;
    logic [7:0] SHAPE_IN = 8'h00;
    logic       CLEAR_STATS, LATCH_STATS, VALID, BUSY, TIMEOUT_ERR;
    logic [3:0] CODE;

    treasure_scan_controller #(
        .CONFIRM_FRAMES(CONFIRM),
        .MAX_FRAMES(MAXF),
        .ACK_TIMEOUT(TMO)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .VSYNC(VSYNC), .ENABLE(ENABLE), .ACK(ACK),
        .RESULT_IN(RESULT_IN), .SHAPE_IN(SHAPE_IN),
        .CLEAR_STATS(CLEAR_STATS), .LATCH_STATS(LATCH_STATS), .CODE(CODE),
        .VALID(VALID), .BUSY(BUSY), .TIMEOUT_ERR(TIMEOUT_ERR)
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int clear_cnt = 0, latch_cnt = 0, vrise_cnt = 0;
    int last_latch_cyc = -100, vrise_cyc = 0;
    logic valid_prev = 1'b0;
    logic [3:0] exp_q[$];
    logic [1:0] fr_r[MAXF];
    logic [7:0] fr_s[MAXF];

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: counts strobes and scores every report as it appears.
    always @(negedge CLK) begin
        if (CLEAR_STATS) clear_cnt++;
        if (LATCH_STATS) begin
            latch_cnt++;
            last_latch_cyc = cyc;
        end
        if (VALID && !valid_prev) begin
            vrise_cnt++;
            vrise_cyc = cyc;
            check("report_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) check("report_code", int'(CODE), int'(exp_q.pop_front()));
            check("report_latency", cyc - last_latch_cyc, 2);
        end
        valid_prev = VALID;
    end

    // Spec-level classification of one frame.
    function automatic logic [3:0] classify(input logic [1:0] r, input logic [7:0] s);
        logic [1:0] sh;
        case (s)
            8'hE0:   sh = 2'd1;
            8'h1C:   sh = 2'd2;
            8'h03:   sh = 2'd3;
            default: sh = 2'd0;
        endcase
        if (r == 2'b00 || r == 2'b11) return 4'd0;
        return {r, sh};
    endfunction

    // Reference: first frame ending a run of CONFIRM equal nonzero codes, else "none" after MAXF.
    task automatic model(output logic [3:0] code, output int n);
        logic [3:0] c[MAXF];
        int run;
        bit found;
        code = 4'd0;
        n = MAXF;
        found = 0;
        for (int i = 0; i < MAXF && !found; i++) begin
            c[i] = classify(fr_r[i], fr_s[i]);
            run = 1;
            for (int j = i - 1; j >= 0; j--) begin
                if (c[j] != c[i]) break;
                run++;
            end
            if (run == CONFIRM && c[i] != 4'd0) begin
                code = c[i];
                n = i + 1;
                found = 1;
            end
        end
    endtask

    task automatic drive_frame(input int i);
        @(negedge CLK);
        VSYNC = 1'b0;
        RESULT_IN = fr_r[i];
        SHAPE_IN = fr_s[i];
        repeat (20) @(negedge CLK);
        VSYNC = 1'b1;
        repeat (12) @(negedge CLK);
    endtask

    task automatic run_scan(input logic [3:0] ec, input int n, input bit do_ack);
        int c0, l0, k;
        exp_q.push_back(ec);
        c0 = clear_cnt;
        l0 = latch_cnt;
        @(negedge CLK);
        ENABLE = 1'b1;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < n; i++) drive_frame(i);
        k = 0;
        while (!VALID && k < 200) begin @(negedge CLK); k++; end
        check("valid_seen", int'(VALID), 1);
        ENABLE = 1'b0;
        check("clear_count", clear_cnt - c0, n);
        check("latch_count", latch_cnt - l0, n);
        if (do_ack) begin
            ACK = 1'b1;
            k = 0;
            while (VALID && k < 50) begin @(negedge CLK); k++; end
            check("valid_drop_on_ack", int'(VALID), 0);
            ACK = 1'b0;
            k = 0;
            while (BUSY && k < 50) begin @(negedge CLK); k++; end
            check("idle_after_release", int'(BUSY), 0);
        end else begin
            k = 0;
            while (VALID && k < 300) begin @(negedge CLK); k++; end
            check("timeout_valid_cycles", cyc - vrise_cyc, TMO);
            check("timeout_err_set", int'(TIMEOUT_ERR), 1);
            check("busy_after_timeout", int'(BUSY), 0);
        end
        repeat (4) @(negedge CLK);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clear"}, int'(CLEAR_STATS), 0);
        check({tag, "_latch"}, int'(LATCH_STATS), 0);
        check({tag, "_code"}, int'(CODE), 0);
        check({tag, "_valid"}, int'(VALID), 0);
        check({tag, "_busy"}, int'(BUSY), 0);
        check({tag, "_err"}, int'(TIMEOUT_ERR), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] ec;
        int n, c0, l0, v0;
        logic [7:0] shapes[4];
        shapes[0] = 8'hE0; shapes[1] = 8'h1C; shapes[2] = 8'h03; shapes[3] = 8'h5A;

        repeat (3) @(negedge CLK);
        check_all_zero("reset");
        RST_N = 1'b1;
        repeat (5) @(negedge CLK);

        // Red triangle every frame: confirmed after the third frame.
        for (int i = 0; i < MAXF; i++) begin fr_r[i] = 2'b01; fr_s[i] = 8'hE0; end
        run_scan(4'b0101, 3, 1);

        // Blue square twice, then red diamond three times.
        fr_r[0] = 2'b10; fr_s[0] = 8'h1C;
        fr_r[1] = 2'b10; fr_s[1] = 8'h1C;
        for (int i = 2; i < 5; i++) begin fr_r[i] = 2'b01; fr_s[i] = 8'h03; end
        run_scan(4'b0111, 5, 1);

        // No colour for the whole scan: "no treasure" after the last frame.
        for (int i = 0; i < MAXF; i++) begin fr_r[i] = 2'b00; fr_s[i] = shapes[i % 4]; end
        run_scan(4'b0000, MAXF, 1);

        // Confirmed report never acknowledged, then ENABLE rising edge clears the error.
        for (int i = 0; i < MAXF; i++) begin fr_r[i] = 2'b01; fr_s[i] = 8'hE0; end
        run_scan(4'b0101, 3, 0);
        @(negedge CLK);
        ENABLE = 1'b1;
        @(negedge CLK);
        check("err_cleared_by_enable", int'(TIMEOUT_ERR), 0);
        ENABLE = 1'b0;
        repeat (4) @(negedge CLK);

        // Sub-cycle VSYNC glitch, then ENABLE dropped during frame 2.
        @(negedge CLK);
        ENABLE = 1'b1;
        repeat (3) @(negedge CLK);
        c0 = clear_cnt; l0 = latch_cnt; v0 = vrise_cnt;
        @(posedge CLK);
        #2 VSYNC = 1'b0;
        #2 VSYNC = 1'b1;
        repeat (6) @(negedge CLK);
        check("glitch_no_clear", clear_cnt - c0, 0);
        check("busy_in_align", int'(BUSY), 1);
        drive_frame(0);
        @(negedge CLK);
        VSYNC = 1'b0;
        repeat (5) @(negedge CLK);
        ENABLE = 1'b0;
        @(negedge CLK);
        check("abort_idle_next_cycle", int'(BUSY), 0);
        repeat (15) @(negedge CLK);
        VSYNC = 1'b1;
        repeat (12) @(negedge CLK);
        check("abort_latch_count", latch_cnt - l0, 1);
        check("abort_clear_count", clear_cnt - c0, 2);
        check("abort_no_valid", vrise_cnt - v0, 0);

        // Reset pulse in the middle of an accumulating frame.
        @(negedge CLK);
        ENABLE = 1'b1;
        repeat (3) @(negedge CLK);
        VSYNC = 1'b0;
        repeat (8) @(negedge CLK);
        check("busy_in_accum", int'(BUSY), 1);
        #1 RST_N = 1'b0;
        #1 check_all_zero("mid_reset");
        @(negedge CLK);
        RST_N = 1'b1;
        ENABLE = 1'b0;
        VSYNC = 1'b1;
        repeat (8) @(negedge CLK);

        // Randomised scans against the reference model.
        for (int s = 0; s < 8; s++) begin
            for (int i = 0; i < MAXF; i++) begin
                if (i > 0 && $urandom_range(0, 99) < 55) begin
                    fr_r[i] = fr_r[i-1];
                    fr_s[i] = fr_s[i-1];
                end else begin
                    fr_r[i] = 2'($urandom_range(0, 3));
                    fr_s[i] = ($urandom_range(0, 3) == 3) ? 8'($urandom) : shapes[$urandom_range(0, 2)];
                end
            end
            model(ec, n);
            run_scan(ec, n, 1);
        end

        check("queue_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
